pipe_stage_chain: RTL and testbench

Parametrised pipeline-register chain that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers of the pipelined CPU into one reusable block. It has DEPTH stages of WIDTH bits, each with its own valid bit, and supports per-stage stall, per-stage flush with younger-stage kill, and bubble collapse. Upstream and downstream connect through valid/ready handshakes. Both cores instantiate it as the pipeline backbone, and its retire/kill counters feed the performance monitor.

---
 rtl/pipe_stage_chain.sv | 108 ++++++++++
 tb/tb_pipe_stage_chain.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register backbone: DEPTH valid/data stages with per-stage
// stall, flush (kills the stage and everything younger), bubble collapse and statistics.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int CNT_W = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         in_ready_o,
    input  logic [DEPTH-1:0]             stall_i,
    input  logic [DEPTH-1:0]             flush_i,
    output logic                         out_valid_o,
    output logic [WIDTH-1:0]             out_data_o,
    input  logic                         out_ready_i,
    output logic [DEPTH-1:0]             stage_valid_o,
    output logic [DEPTH*WIDTH-1:0]       stage_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic [CNT_W-1:0]             retire_cnt_o,
    output logic [CNT_W-1:0]             kill_cnt_o
);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] kill_cnt_q;

    logic [DEPTH:0]   hold;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic             in_ready;
    logic             out_valid;
    logic             retire;
    logic [CNT_W-1:0] kill_sum;

    function automatic int unsigned popcnt(input logic [DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // Hold ripples from the output backwards; an empty stage never holds on back-pressure.
    always_comb begin
        hold = '0;
        kill = '0;
        hold[DEPTH] = ~out_ready_i;
        for (int s = DEPTH-1; s >= 0; s--) begin
            hold[s] = stall_i[s] | (valid_q[s] & hold[s+1]);
        end
        kill[DEPTH-1] = flush_i[DEPTH-1];
        for (int s = DEPTH-2; s >= 0; s--) begin
            kill[s] = kill[s+1] | flush_i[s];
        end
    end

    always_comb begin
        in_ready     = ~hold[0] & ~(|flush_i);
        out_valid    = valid_q[DEPTH-1] & ~stall_i[DEPTH-1] & ~flush_i[DEPTH-1];
        retire       = out_valid & out_ready_i;
        src_valid    = '0;
        src_valid[0] = in_valid_i & in_ready;
        src_data[0]  = in_data_i;
        for (int s = 1; s < DEPTH; s++) begin
            src_valid[s] = valid_q[s-1] & ~hold[s-1] & ~kill[s-1];
            src_data[s]  = data_q[s-1];
        end
        kill_sum = CNT_W'(popcnt(valid_q & kill));
    end

    // Kill beats hold; data is only overwritten when a real payload arrives.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            retire_cnt_q <= '0;
            kill_cnt_q   <= '0;
            for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (kill[s]) begin
                    valid_q[s] <= 1'b0;
                end else if (!hold[s]) begin
                    valid_q[s] <= src_valid[s];
                    if (src_valid[s]) data_q[s] <= src_data[s];
                end
            end
            if (retire) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            kill_cnt_q <= kill_cnt_q + kill_sum;
        end
    end

    always_comb begin
        stage_data_o = '0;
        for (int s = 0; s < DEPTH; s++) stage_data_o[s*WIDTH +: WIDTH] = data_q[s];
    end

    assign in_ready_o    = in_ready;
    assign out_valid_o   = out_valid;
    assign out_data_o    = data_q[DEPTH-1];
    assign stage_valid_o = valid_q;
    assign occupancy_o   = OCC_W'(popcnt(valid_q));
    assign retire_cnt_o  = retire_cnt_q;
    assign kill_cnt_o    = kill_cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (WIDTH=8, DEPTH=5, CNT_W=4): streaming, back-pressure,
// stall bubble collapse, flush/kill accounting and asynchronous reset with counter wrap.
module tb_pipe_stage_chain;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [4:0]  stage_valid;
    logic [39:0] stage_data;
    logic [2:0]  occupancy;
    logic [3:0]  retire_cnt;
    logic [3:0]  kill_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pipe_stage_chain #(.WIDTH(8), .DEPTH(5), .CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .stall_i      (stall),
        .flush_i      (flush),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .stage_valid_o(stage_valid),
        .stage_data_o (stage_data),
        .occupancy_o  (occupancy),
        .retire_cnt_o (retire_cnt),
        .kill_cnt_o   (kill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = 8'h00;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        rst_n     = 1'b1;
    endtask

    logic [4:0] stall_sv [3];

    initial begin
        stall_sv[0] = 5'b10011;
        stall_sv[1] = 5'b10111;
        stall_sv[2] = 5'b11111;

        // Reset values
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        stall = '0; flush = '0; out_ready = 1'b0;
        #2;
        chk("rst_valid", stage_valid, 5'b0);
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_retire", retire_cnt, 4'd0);
        chk("rst_kill", kill_cnt, 4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        stall = 5'b00001;
        #1;
        chk("rst_in_ready_stall0", in_ready, 1'b0);
        stall = '0;
        rst_n = 1'b1;

        // Stream A0..A4 with the sink always ready
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 5) begin
                chk("lat_no_valid", out_valid, 1'b0);
            end else begin
                chk("stream_valid", out_valid, 1'b1);
                chk("stream_data", out_data, 8'hA0 + k - 5);
            end
            in_data  = 8'(8'hA0 + k);
            in_valid = (k < 5);
        end
        tick();
        chk("stream_retire", retire_cnt, 4'd5);
        chk("stream_occ", occupancy, 3'd0);

        // Back-pressure: seven offered, five fit
        do_reset();
        in_valid = 1'b1; in_data = 8'hB0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_fill", in_ready, 1'b1);
            tick();
            in_data = 8'(8'hB0 + i + 1);
        end
        chk("bp_occ_full", occupancy, 3'd5);
        chk("bp_ready_full", in_ready, 1'b0);
        chk("bp_head", out_data, 8'hB0);
        tick();
        tick();
        chk("bp_occ_hold", occupancy, 3'd5);
        chk("bp_stage0", stage_data[7:0], 8'hB4);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", in_ready, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("bp_drain_valid", out_valid, 1'b1);
            chk("bp_drain_data", out_data, 8'hB0 + j);
            if (j == 1) in_data = 8'hB6;
            if (j == 2) in_valid = 1'b0;
        end
        tick();
        chk("bp_retire", retire_cnt, 4'd7);
        chk("bp_occ_empty", occupancy, 3'd0);

        // Stall on the oldest stage with a bubble-filled chain
        do_reset();
        in_valid = 1'b1; in_data = 8'hC0;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        in_valid = 1'b1; in_data = 8'hC1;
        tick();
        in_valid = 1'b0;
        chk("st_sparse", stage_valid, 5'b10001);
        stall = 5'b10000; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hC2;
        #1;
        chk("st_out_valid", out_valid, 1'b0);
        chk("st_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("st_out_valid_hold", out_valid, 1'b0);
            chk("st_collapse", stage_valid, stall_sv[c]);
            in_data = 8'(8'hC3 + c);
        end
        chk("st_stage3", stage_data[31:24], 8'hC1);
        chk("st_backed_up", in_ready, 1'b0);
        chk("st_head", out_data, 8'hC0);
        stall = '0;
        #1;
        chk("st_release_valid", out_valid, 1'b1);
        chk("st_release_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("st_next_head", out_data, 8'hC1);
        chk("st_retire", retire_cnt, 4'd1);

        // Flush of stage 2 kills stages 0..2 and the input
        do_reset();
        in_valid = 1'b1; in_data = 8'hD0;
        for (int i = 0; i < 5; i++) begin
            tick();
            in_data = 8'(8'hD1 + i);
        end
        flush = 5'b00100;
        #1;
        chk("fl_in_ready", in_ready, 1'b0);
        chk("fl_out_valid", out_valid, 1'b1);
        tick();
        flush = '0;
        in_valid = 1'b0;
        chk("fl_valid", stage_valid, 5'b11000);
        chk("fl_kill", kill_cnt, 4'd3);
        chk("fl_s3", stage_data[31:24], 8'hD1);
        out_ready = 1'b1;
        tick();
        chk("fl_continue_data", out_data, 8'hD1);
        chk("fl_continue_valid", stage_valid, 5'b10000);
        chk("fl_retire", retire_cnt, 4'd1);

        // Flush beats a stall; the oldest stage still retires
        do_reset();
        in_valid = 1'b1; in_data = 8'hE0;
        for (int i = 0; i < 5; i++) begin
            tick();
            in_data = 8'(8'hE1 + i);
        end
        in_valid = 1'b0; stall = 5'b00100; flush = 5'b01000; out_ready = 1'b1;
        #1;
        chk("sf_out_valid", out_valid, 1'b1);
        tick();
        stall = '0; flush = '0;
        chk("sf_valid", stage_valid, 5'b00000);
        chk("sf_retire", retire_cnt, 4'd1);
        chk("sf_kill", kill_cnt, 4'd4);

        // Asynchronous reset mid-stream, then counter wrap
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            in_data = 8'(8'h11 + i);
        end
        chk("ar_pre_retire", retire_cnt, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", stage_valid, 5'b0);
        chk("ar_occ", occupancy, 3'd0);
        chk("ar_out_valid", out_valid, 1'b0);
        chk("ar_out_data", out_data, 8'h00);
        chk("ar_retire", retire_cnt, 4'd0);
        #1;
        rst_n = 1'b1;
        in_data = 8'h20;
        for (int i = 0; i < 17; i++) begin
            tick();
            in_data = 8'(8'h21 + i);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("wrap_retire", retire_cnt, 4'd1);
        chk("wrap_occ", occupancy, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
